// File: rtl/input_debounce_pkg.sv
// ============================================================================
// input_debounce_pkg : shared constants for the four-channel input debouncer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package input_debounce_pkg;

  localparam int NUM_CH = 4;

  localparam int CH_A = 3;
  localparam int CH_B = 2;
  localparam int CH_C = 1;
  localparam int CH_D = 0;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int SYNC_STAGES_DEF     = 2;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/input_debounce_if.sv
// ============================================================================
// input_debounce_if : raw lines in, debounced levels and edge pulses out
// Rev 1.0 - initial release (fall only with INPUT_DEBOUNCE_FALL_EN)
// ============================================================================
`default_nettype none

interface input_debounce_if;
  import input_debounce_pkg::*;

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] lvl;
  logic [NUM_CH-1:0] rise;
`ifdef INPUT_DEBOUNCE_FALL_EN
  logic [NUM_CH-1:0] fall;
`endif

  modport master (
    output raw,
    input  lvl,
    input  rise
`ifdef INPUT_DEBOUNCE_FALL_EN
    ,
    input  fall
`endif
  );

  modport slave (
    input  raw,
    output lvl,
    output rise
`ifdef INPUT_DEBOUNCE_FALL_EN
    ,
    output fall
`endif
  );

endinterface

`default_nettype wire

// File: rtl/input_debounce_chan.sv
// ============================================================================
// debounce_chan : synchronizer, stability counter, level and edge flops for
//                 one channel. Optional fall pulse: INPUT_DEBOUNCE_FALL_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_chan
  import input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic lvl_o,
  output logic rise_o
`ifdef INPUT_DEBOUNCE_FALL_EN
  ,
  output logic fall_o
`endif
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   rise_q, rise_d;
`ifdef INPUT_DEBOUNCE_FALL_EN
  logic                   fall_q, fall_d;
`endif
  logic                   w_sync;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
  assign w_sync = sync_q[SYNC_STAGES-1];

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_comb begin
    cnt_d  = '0;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
`ifdef INPUT_DEBOUNCE_FALL_EN
    fall_d = 1'b0;
`endif
    if (w_sync != lvl_q) begin
      if (cnt_q == CNT_MAX) begin
        lvl_d  = ~lvl_q;
        rise_d = ~lvl_q;
`ifdef INPUT_DEBOUNCE_FALL_EN
        fall_d = lvl_q;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
`ifdef INPUT_DEBOUNCE_FALL_EN
      fall_q <= 1'b0;
`endif
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
`ifdef INPUT_DEBOUNCE_FALL_EN
      fall_q <= fall_d;
`endif
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
`ifdef INPUT_DEBOUNCE_FALL_EN
  assign fall_o = fall_q;
`endif

endmodule

`default_nettype wire

// File: rtl/input_debounce.sv
// ============================================================================
// input_debounce : four independent debounced channels feeding the priority
//                  encoder (bit 3 = a ... bit 0 = d). Macro: INPUT_DEBOUNCE_FALL_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input_debounce_if.slave  bus
);

  logic [NUM_CH-1:0] w_lvl;
  logic [NUM_CH-1:0] w_rise;
`ifdef INPUT_DEBOUNCE_FALL_EN
  logic [NUM_CH-1:0] w_fall;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (bus.raw[i]),
      .lvl_o  (w_lvl[i]),
      .rise_o (w_rise[i])
`ifdef INPUT_DEBOUNCE_FALL_EN
      ,
      .fall_o (w_fall[i])
`endif
    );
  end

  assign bus.lvl  = w_lvl;
  assign bus.rise = w_rise;
`ifdef INPUT_DEBOUNCE_FALL_EN
  assign bus.fall = w_fall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_debounce.sv
// ============================================================================
// tb_input_debounce : directed stimulus with a window-based reference model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debounce;
  import input_debounce_pkg::*;

  localparam int D0 = 16;
  localparam int S0 = 2;
  localparam int D1 = 1;
  localparam int S1 = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  input_debounce_if bus0 ();
  input_debounce_if bus1 ();

  input_debounce #(.DEBOUNCE_CYCLES(D0), .SYNC_STAGES(S0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  input_debounce #(.DEBOUNCE_CYCLES(D1), .SYNC_STAGES(S1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Level flips once the last d samples seen by the level logic (s edges old)
  // all disagree with the current level; samples before reset count as 0.
  function automatic logic [3:0] next_lvl(input logic [3:0] h[$], input int s,
                                          input int d, input logic [3:0] cur);
    logic [3:0] r;
    int         n;
    logic       v;
    bit         steady;
    r = cur;
    n = h.size() - 1;
    for (int ch = 0; ch < 4; ch++) begin
      steady = 1'b1;
      for (int k = n - s - d + 1; k <= n - s; k++) begin
        v = (k >= 0) ? h[k][ch] : 1'b0;
        if (v == cur[ch]) steady = 1'b0;
      end
      if (steady) r[ch] = ~cur[ch];
    end
    return r;
  endfunction

  logic [3:0] h0[$];
  logic [3:0] h1[$];
  logic [3:0] m_lvl0, m_rise0, m_fall0;
  logic [3:0] m_lvl1, m_rise1, m_fall1;
  logic [3:0] nl;
  bit         m_valid = 1'b0;

  // Compare on the falling edge, then advance the model with the values the
  // next rising edge will sample.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("lvl0",  bus0.lvl,  m_lvl0);
      check("rise0", bus0.rise, m_rise0);
      check("lvl1",  bus1.lvl,  m_lvl1);
      check("rise1", bus1.rise, m_rise1);
`ifdef INPUT_DEBOUNCE_FALL_EN
      check("fall0", bus0.fall, m_fall0);
      check("fall1", bus1.fall, m_fall1);
`endif
    end
    if (rst) begin
      h0.delete();
      h1.delete();
      m_lvl0 = '0; m_rise0 = '0; m_fall0 = '0;
      m_lvl1 = '0; m_rise1 = '0; m_fall1 = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      h0.push_back(bus0.raw);
      nl      = next_lvl(h0, S0, D0, m_lvl0);
      m_rise0 = nl & ~m_lvl0;
      m_fall0 = ~nl & m_lvl0;
      m_lvl0  = nl;
      h1.push_back(bus1.raw);
      nl      = next_lvl(h1, S1, D1, m_lvl1);
      m_rise1 = nl & ~m_lvl1;
      m_fall1 = ~nl & m_lvl1;
      m_lvl1  = nl;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst      = 1'b1;
    bus0.raw = 4'b1111;
    bus1.raw = 4'b0000;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold_lvl",  bus0.lvl,  4'b0000);
      check("rst_hold_rise", bus0.rise, 4'b0000);
    end

    // Lines already high at release are fresh transitions.
    rst = 1'b0;
    ticks(17);
    check("post_rst_e16_lvl", bus0.lvl, 4'b0000);
    tick();
    check("post_rst_e17_lvl",  bus0.lvl,  4'b1111);
    check("post_rst_e17_rise", bus0.rise, 4'b1111);
    tick();
    check("post_rst_e18_rise", bus0.rise, 4'b0000);
    check("post_rst_e18_lvl",  bus0.lvl,  4'b1111);

    bus0.raw = 4'b0000;
    ticks(20);
    check("idle_lvl", bus0.lvl, 4'b0000);
    bus0.raw = 4'b0100;
    ticks(17);
    check("press_e16_lvl", bus0.lvl, 4'b0000);
    tick();
    check("press_e17_lvl",  bus0.lvl,  4'b0100);
    check("press_e17_rise", bus0.rise, 4'b0100);
    tick();
    check("press_e18_rise", bus0.rise, 4'b0000);

    bus0.raw = 4'b0001;
    ticks(20);
    check("rel_setup_lvl", bus0.lvl, 4'b0001);
    bus0.raw = 4'b0000;
    ticks(17);
    check("rel_e16_lvl", bus0.lvl, 4'b0001);
    tick();
    check("rel_e17_lvl",  bus0.lvl,  4'b0000);
    check("rel_e17_rise", bus0.rise, 4'b0000);
`ifdef INPUT_DEBOUNCE_FALL_EN
    check("rel_e17_fall", bus0.fall, 4'b0001);
`endif

    // A one-cycle dropout restarts the count.
    bus0.raw = 4'b1000;
    ticks(10);
    bus0.raw = 4'b0000;
    tick();
    bus0.raw = 4'b1000;
    ticks(17);
    check("bounce_e16_lvl", bus0.lvl, 4'b0000);
    tick();
    check("bounce_e17_lvl",  bus0.lvl,  4'b1000);
    check("bounce_e17_rise", bus0.rise, 4'b1000);

    bus0.raw = 4'b0000;
    ticks(20);
    check("pulse_setup_lvl", bus0.lvl, 4'b0000);
    bus0.raw = 4'b1000;
    ticks(15);
    bus0.raw = 4'b0000;
    ticks(20);
    check("pulse15_lvl", bus0.lvl, 4'b0000);

    bus0.raw = 4'b1000;
    ticks(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_lvl", bus0.lvl, 4'b0000);
    ticks(17);
    check("midrst_e16_lvl", bus0.lvl, 4'b0000);
    tick();
    check("midrst_e17_lvl",  bus0.lvl,  4'b1000);
    check("midrst_e17_rise", bus0.rise, 4'b1000);

    // Single-cycle debounce: level lands on edge 2.
    bus1.raw = 4'b0100;
    ticks(2);
    check("d1_e1_lvl", bus1.lvl, 4'b0000);
    tick();
    check("d1_e2_lvl",  bus1.lvl,  4'b0100);
    check("d1_e2_rise", bus1.rise, 4'b0100);
    tick();
    check("d1_e3_rise", bus1.rise, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      bus1.raw[2] = ~bus1.raw[2];
      ticks(3);
    end
    ticks(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
